car_safety_interlock_seq: RTL and testbench

CAR_SAFETY_INTERLOCK_SEQ -- requirements
Module: car_safety_interlock_seq

---
 rtl/car_safety_interlock_seq.sv | 202 ++++++++++++++++++++
 tb/tb_car_safety_interlock_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/car_safety_interlock_seq.sv
`default_nettype none
// ============================================================================
// Module      : car_safety_interlock_seq
// Description : Ignition/start interlock for a vehicle.
//               - Debounces the key, belt, door, brake, park and health inputs.
//               - Sequences OFF -> CHECK -> READY -> RUN, and moves to LOCK
//                 after too many refused start requests.
//               - Drives seat-belt and per-channel fault warnings.
//               - Drives a square-wave chime.
// Revision    : 1.0 - initial release
// ============================================================================
module car_safety_interlock_seq #(
  parameter int N_FAULT    = 6,
  parameter int DEB_CYC    = 4,
  parameter int MAX_TRY    = 3,
  parameter int CHIME_HALF = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key,
  input  logic               sb,
  input  logic               door,
  input  logic               brk,
  input  logic               park,
  input  logic [N_FAULT-1:0] fault_ok,
  input  logic               srv,
  input  logic               start_req,
  output logic               start_permit,
  output logic               engine_on,
  output logic               lockout,
  output logic               chime,
  output logic               seat_warn,
  output logic [N_FAULT-1:0] fault_warn,
  output logic [2:0]         state
);

  // Debounced channels: key, sb, door, brk, park, then one per health input.
  localparam int         c_num_ch      = 5 + N_FAULT;
  localparam logic [7:0] c_deb_last    = 8'(DEB_CYC - 1);
  localparam logic [3:0] c_max_try     = 4'(MAX_TRY);
  localparam logic [8:0] c_chime_half  = 9'(CHIME_HALF);
  localparam logic [8:0] c_chime_last  = 9'(2 * CHIME_HALF - 1);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_CHECK = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_LOCK  = 3'd4
  } state_t;

  logic [c_num_ch-1:0] w_raw;
  logic [c_num_ch-1:0] w_filt;
  logic                w_key_f;
  logic                w_sb_f;
  logic                w_door_f;
  logic                w_brk_f;
  logic                w_park_f;
  logic [N_FAULT-1:0]  w_fault_f;
  logic                w_ok;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_try;
  logic [3:0]          w_try_nxt;
  logic [3:0]          w_try_inc;

  logic                w_chime_en;
  logic [8:0]          r_chime_cnt;
  logic                r_chime;

  assign w_raw = {fault_ok, park, brk, door, sb, key};

  // One independent debouncer per channel. The filtered value follows the raw
  // value only after DEB_CYC consecutive differing samples.
  for (genvar g = 0; g < c_num_ch; g++) begin : g_deb
    logic [7:0] r_cnt;
    logic       r_f;

    // Count consecutive disagreeing samples; any agreeing sample restarts.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= 8'd0;
        r_f   <= 1'b0;
      end else if (w_raw[g] != r_f) begin
        if (r_cnt == c_deb_last) begin
          r_f   <= w_raw[g];
          r_cnt <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end

    assign w_filt[g] = r_f;
  end

  assign w_key_f   = w_filt[0];
  assign w_sb_f    = w_filt[1];
  assign w_door_f  = w_filt[2];
  assign w_brk_f   = w_filt[3];
  assign w_park_f  = w_filt[4];
  assign w_fault_f = w_filt[c_num_ch-1:5];

  // Service mode waives only the belt and door conditions.
  assign w_ok = (&w_fault_f) & w_brk_f & w_park_f & (srv | (w_sb_f & w_door_f));

  // Retry counter saturates rather than wrapping.
  assign w_try_inc = (r_try == 4'hF) ? r_try : r_try + 4'd1;

  // State and retry-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OFF;
      r_try   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_try   <= w_try_nxt;
    end
  end

  // Next-state logic. Key-off takes priority in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_try_nxt   = r_try;
    if (!w_key_f) begin
      w_state_nxt = S_OFF;
      w_try_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_CHECK;
        end
        S_CHECK: begin
          if (w_ok) begin
            w_state_nxt = S_READY;
          end else if (start_req) begin
            w_try_nxt = w_try_inc;
            if (w_try_inc == c_max_try) begin
              w_state_nxt = S_LOCK;
            end
          end
        end
        S_READY: begin
          if (!w_ok) begin
            w_state_nxt = S_CHECK;
          end else if (start_req) begin
            w_state_nxt = S_RUN;
            w_try_nxt   = 4'd0;
          end
        end
        S_RUN: begin
          // Running engine is never dropped on loss of OK; only key-off stops it.
          w_state_nxt = S_RUN;
        end
        S_LOCK: begin
          // Start requests are ignored; only key-off clears the lockout.
          w_state_nxt = S_LOCK;
        end
        default: begin
          w_state_nxt = S_OFF;
          w_try_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Moore decodes of the state register.
  assign state        = r_state;
  assign start_permit = (r_state == S_READY);
  assign engine_on    = (r_state == S_RUN);
  assign lockout      = (r_state == S_LOCK);

  // Warnings come straight from the filtered registers.
  assign seat_warn  = w_key_f & ~w_sb_f;
  assign fault_warn = {N_FAULT{w_key_f}} & ~w_fault_f;

  assign w_chime_en = (seat_warn & (r_state != S_OFF))
                    | (r_state == S_LOCK)
                    | ((r_state == S_RUN) & ~w_door_f);

  // Chime phase counter: high for the first half-period, low for the second.
  // Dropping the enable silences the chime and rewinds the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chime_cnt <= 9'd0;
      r_chime     <= 1'b0;
    end else if (!w_chime_en) begin
      r_chime_cnt <= 9'd0;
      r_chime     <= 1'b0;
    end else begin
      r_chime     <= (r_chime_cnt < c_chime_half);
      r_chime_cnt <= (r_chime_cnt == c_chime_last) ? 9'd0 : r_chime_cnt + 9'd1;
    end
  end

  assign chime = r_chime;

endmodule
`default_nettype wire

// File: tb/tb_car_safety_interlock_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_safety_interlock_seq
// Description : Directed self-checking bench for car_safety_interlock_seq
//               at default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_safety_interlock_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic       sb;
  logic       door;
  logic       brk;
  logic       park;
  logic [5:0] fault_ok;
  logic       srv;
  logic       start_req;
  logic       start_permit;
  logic       engine_on;
  logic       lockout;
  logic       chime;
  logic       seat_warn;
  logic [5:0] fault_warn;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  car_safety_interlock_seq #(
    .N_FAULT   (6),
    .DEB_CYC   (4),
    .MAX_TRY   (3),
    .CHIME_HALF(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .sb          (sb),
    .door        (door),
    .brk         (brk),
    .park        (park),
    .fault_ok    (fault_ok),
    .srv         (srv),
    .start_req   (start_req),
    .start_permit(start_permit),
    .engine_on   (engine_on),
    .lockout     (lockout),
    .chime       (chime),
    .seat_warn   (seat_warn),
    .fault_warn  (fault_warn),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
  endtask

  // Length of the current chime run at level lvl, bounded.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (chime === lvl && len < 40) begin
      len++;
      tick();
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({state, start_permit, engine_on, lockout, chime, seat_warn, fault_warn});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int hi_len;
    int lo_len;

    rst = 1'b1; key = 1'b0; sb = 1'b1; door = 1'b1; brk = 1'b1; park = 1'b1;
    fault_ok = 6'h3F; srv = 1'b0; start_req = 1'b0;

    // Reset state
    tick(2);
    check("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    tick(6);
    check("idle_state", 32'(state), 32'd0);
    check("idle_outs", all_outs(), 32'd0);

    // Key glitch of 3 cycles must be filtered out completely
    key = 1'b1;
    tick(3);
    key = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("glitch_outs", all_outs(), 32'd0);
    end

    // Clean key-on: CHECK at k+4, READY at k+5, RUN on start
    key = 1'b1;
    tick(4);
    check("keyon_k3_state", 32'(state), 32'd0);
    tick();
    check("keyon_k4_state", 32'(state), 32'd1);
    tick();
    check("keyon_k5_state", 32'(state), 32'd2);
    check("keyon_k5_permit", 32'(start_permit), 32'd1);
    pulse_start();
    check("start_state", 32'(state), 32'd3);
    check("start_engine", 32'(engine_on), 32'd1);
    check("start_permit_low", 32'(start_permit), 32'd0);

    // In RUN, brake and park release do not stop the engine
    brk = 1'b0; park = 1'b0;
    tick(6);
    check("run_hold_state", 32'(state), 32'd3);
    check("run_quiet_chime", 32'(chime), 32'd0);

    // Door opens: chime starts the edge after door_f falls, 8 high then low
    door = 1'b0;
    tick(4);
    check("door_f_edge_chime", 32'(chime), 32'd0);
    tick();
    check("door_chime_first", 32'(chime), 32'd1);
    tick(7);
    check("door_chime_last_hi", 32'(chime), 32'd1);
    tick();
    check("door_chime_first_lo", 32'(chime), 32'd0);
    check("door_run_state", 32'(state), 32'd3);

    // Asynchronous reset mid-RUN
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", all_outs(), 32'd0);
    tick();
    check("rst_held_outs", all_outs(), 32'd0);
    door = 1'b1; brk = 1'b1; park = 1'b1;
    rst = 1'b0;

    // Key held through reset still needs a full debounce
    tick(4);
    check("post_rst_k3_state", 32'(state), 32'd0);
    tick();
    check("post_rst_check", 32'(state), 32'd1);
    tick();
    check("post_rst_ready", 32'(state), 32'd2);

    // Belt unfastened: back to CHECK, three refused starts lock out
    sb = 1'b0;
    tick(4);
    check("sb_open_ready", 32'(state), 32'd2);
    check("sb_seat_warn", 32'(seat_warn), 32'd1);
    tick();
    check("sb_open_check", 32'(state), 32'd1);
    pulse_start();
    check("try1_state", 32'(state), 32'd1);
    pulse_start();
    check("try2_state", 32'(state), 32'd1);
    pulse_start();
    check("try3_state", 32'(state), 32'd4);
    check("try3_lockout", 32'(lockout), 32'd1);

    // Chime period while locked
    w = 0;
    while (chime !== 1'b0 && w < 40) begin w++; tick(); end
    while (chime !== 1'b1 && w < 80) begin w++; tick(); end
    check("lock_chime_found", 32'(chime), 32'd1);
    run_len(1'b1, hi_len);
    run_len(1'b0, lo_len);
    check("lock_chime_hi_len", 32'(hi_len), 32'd8);
    check("lock_chime_lo_len", 32'(lo_len), 32'd8);

    // Start requests are ignored in LOCK
    pulse_start();
    check("lock_ignore_start", 32'(state), 32'd4);

    // Key off for a full debounce returns to OFF
    key = 1'b0;
    tick(4);
    check("keyoff_lock_held", 32'(state), 32'd4);
    tick();
    check("keyoff_state", 32'(state), 32'd0);
    check("keyoff_lockout", 32'(lockout), 32'd0);
    tick();
    check("keyoff_chime", 32'(chime), 32'd0);
    check("keyoff_seat_warn", 32'(seat_warn), 32'd0);

    // Retry counter was cleared: two refusals again stay in CHECK
    key = 1'b1;
    tick(5);
    check("retry_check", 32'(state), 32'd1);
    pulse_start();
    pulse_start();
    check("retry_two_check", 32'(state), 32'd1);
    pulse_start();
    check("retry_three_lock", 32'(state), 32'd4);
    key = 1'b0;
    tick(5);
    check("retry_off", 32'(state), 32'd0);

    // Service mode bypasses belt and door; a health fault drops READY
    door = 1'b0; srv = 1'b1; key = 1'b1;
    tick(6);
    check("srv_ready", 32'(state), 32'd2);
    check("srv_permit", 32'(start_permit), 32'd1);
    check("srv_fault_warn_clear", 32'(fault_warn), 32'd0);
    fault_ok = 6'b111011;
    tick(4);
    check("fault_warn_bit2", 32'(fault_warn), 32'h04);
    check("fault_still_ready", 32'(state), 32'd2);
    tick();
    check("fault_to_check", 32'(state), 32'd1);
    check("fault_permit_low", 32'(start_permit), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
